bin2bcd_seq: RTL and testbench

sequential double-dabble converter between the 16-bit cycle counter and the seven-segment display driver; converts the binary cycle count to 4 packed BCD digits.

Interface
REQ-001 The block SHALL have parameter SAT_EN, default 1: 1 = saturate out-of-range results to 9999; 0 = output the low 4 decimal digits (value mod 10000).
REQ-002 The block SHALL have port clk, input, 1 bit: sole clock; all state changes occur on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port i_start, input, 1 bit: conversion request; sampled only in IDLE.
REQ-005 The block SHALL have port i_bin, input, 16 bits: unsigned binary value, captured on the accepting edge.
REQ-006 The block SHALL have port o_busy, output, 1 bit: high while a conversion is in progress.
REQ-007 The block SHALL have port o_done, output, 1 bit: one-cycle pulse marking that the result has been updated.
REQ-008 The block SHALL have port o_bcd, output, 16 bits: packed BCD with [15:12] = thousands and [3:0] = units; held between conversions.
REQ-009 The block SHALL have port o_overflow, output, 1 bit: high when the last converted value exceeded 9999; updated with o_bcd.

Function
REQ-010 The block SHALL implement three states: IDLE, SHIFT and FINISH.
REQ-011 In IDLE, an edge with i_start=1 SHALL capture i_bin into a 16-bit shift register, clear a 20-bit (5-digit) BCD accumulator, clear the iteration counter, set o_busy=1 and go to SHIFT.
REQ-012 In IDLE with i_start=0, the block SHALL hold all state and outputs.
REQ-013 In SHIFT, each edge SHALL first add 3 to every accumulator digit that is >=5, then shift {accumulator, shift register} left by 1 bit and increment the counter.
REQ-014 The block SHALL go from SHIFT to FINISH on the edge that completes the 16th iteration (counter value 15 at that edge).
REQ-015 The FINISH edge SHALL load the outputs, clear o_busy, set o_done=1 and go to IDLE.
REQ-016 At the FINISH edge, if the accumulator's ten-thousands digit is zero: o_bcd = low 4 digits and o_overflow = 0.
REQ-017 At the FINISH edge, if the ten-thousands digit is nonzero: o_overflow = 1, and o_bcd = 16'h9999 when SAT_EN=1, or the low 4 digits when SAT_EN=0.
REQ-018 o_done SHALL clear on the edge following FINISH and never be high for more than one cycle per conversion.
REQ-019 Latency: with the accepting edge as E0, shifts occur on E1..E16 and outputs update at E17; o_done is high between E17 and E18.
REQ-020 i_start SHALL be ignored while in SHIFT or FINISH; no request is queued.
REQ-021 i_start=1 at E18 (IDLE, o_done high) SHALL be accepted, giving a back-to-back period of 18 cycles.
REQ-022 Changes on i_bin after the accepting edge SHALL NOT affect the conversion in progress.
REQ-023 o_bcd and o_overflow SHALL change only at a FINISH edge or on reset.
REQ-024 Every BCD digit of o_bcd SHALL always be in the range 0-9.

Reset
REQ-025 On a rising edge with reset=1, the block SHALL enter IDLE and set o_busy=0, o_done=0, o_bcd=16'h0000, o_overflow=0, and zero the counter, shift register and accumulator.
REQ-026 Reset SHALL take priority over i_start and over every state transition.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion: no o_done pulse and no partial result on o_bcd.

Verification
REQ-028 Scenario: i_bin=0, start -> o_done at E17, o_bcd=16'h0000, o_overflow=0.
REQ-029 Scenario: i_bin=1234 (16'h04D2), start -> o_bcd=16'h1234, o_overflow=0; then 9999 -> 16'h9999, o_overflow=0.
REQ-030 Scenario: SAT_EN=1 with i_bin=10000 -> o_bcd=16'h9999, o_overflow=1; SAT_EN=0 with i_bin=65535 -> o_bcd=16'h5535, o_overflow=1.
REQ-031 Scenario: start with 42, then hold i_start=1 and change i_bin=777 during E1..E17 -> exactly one o_done with 16'h0042; the second conversion begins at E18 and yields 16'h0777 at E35.
REQ-032 Scenario: start with 500, assert reset at E8 -> no o_done; o_bcd=16'h0000 and o_busy=0 after the reset edge; a new

---
 rtl/bin2bcd_seq.sv | 113 +++++++++++
 tb/tb_bin2bcd_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 16-bit binary to 4 packed BCD digits.
// One shift per cycle; the result and overflow flag update together on the finish cycle.
module bin2bcd_seq #(
  parameter bit SAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [15:0] i_bin,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_bcd,
  output logic        o_overflow
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StFinish = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [19:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic [19:0] acc_adj;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;

    // Digits >= 5 get +3 so the following left shift carries correctly into the next digit.
    acc_adj = acc_q;
    for (int i = 0; i < 5; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          sr_d    = i_bin;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        {acc_d, sr_d} = {acc_adj[18:0], sr_q, 1'b0};
        cnt_d         = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
        if (acc_q[19:16] != 4'd0) begin
          ovf_d = 1'b1;
          bcd_d = SAT_EN ? 16'h9999 : acc_q[15:0];
        end else begin
          ovf_d = 1'b0;
          bcd_d = acc_q[15:0];
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_bcd      = bcd_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a saturating and a wrapping instance share stimulus and are
// compared against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [15:0] i_bin;
  logic        busy_s, done_s, ovf_s;
  logic [15:0] bcd_s;
  logic        busy_m, done_m, ovf_m;
  logic [15:0] bcd_m;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.SAT_EN(1'b1)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_bin      (i_bin),
    .o_busy     (busy_s),
    .o_done     (done_s),
    .o_bcd      (bcd_s),
    .o_overflow (ovf_s)
  );

  bin2bcd_seq #(.SAT_EN(1'b0)) dut_mod (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_bin      (i_bin),
    .o_busy     (busy_m),
    .o_done     (done_m),
    .o_bcd      (bcd_m),
    .o_overflow (ovf_m)
  );

  // Returns {overflow, packed BCD} computed with plain decimal arithmetic.
  function automatic logic [16:0] ref_model(input int unsigned v, input bit sat);
    int unsigned r;
    logic [15:0] b;
    r = v % 10000;
    if (v > 9999 && sat) r = 9999;
    b[15:12] = 4'(r / 1000);
    b[11:8]  = 4'((r / 100) % 10);
    b[7:4]   = 4'((r / 10) % 10);
    b[3:0]   = 4'(r % 10);
    return {(v > 9999), b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full conversion on both instances, checking latency, pulse width and results.
  task automatic convert(input logic [15:0] v, input string name);
    logic [16:0] es, em;
    int lat;
    es = ref_model(int'(v), 1'b1);
    em = ref_model(int'(v), 1'b0);
    i_start = 1'b1;
    i_bin   = v;
    tick();
    i_start = 1'b0;
    checks++;
    if (busy_s !== 1'b1 || busy_m !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_after_accept: got sat=%b mod=%b want 1", name, busy_s, busy_m);
    end
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      i_bin = 16'($urandom);
      tick();
      if (done_s === 1'b1 || done_m === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 17 || done_s !== 1'b1 || done_m !== 1'b1) begin
      failures++;
      $display("FAIL %s done_latency: got %0d (sat=%b mod=%b) want 17", name, lat, done_s,
               done_m);
    end
    checks++;
    if ({ovf_s, bcd_s} !== es) begin
      failures++;
      $display("FAIL %s sat_result v=%0d: got ovf=%b bcd=%h want ovf=%b bcd=%h", name, v,
               ovf_s, bcd_s, es[16], es[15:0]);
    end
    checks++;
    if ({ovf_m, bcd_m} !== em) begin
      failures++;
      $display("FAIL %s mod_result v=%0d: got ovf=%b bcd=%h want ovf=%b bcd=%h", name, v,
               ovf_m, bcd_m, em[16], em[15:0]);
    end
    tick();
    checks++;
    if (done_s !== 1'b0 || done_m !== 1'b0 || busy_s !== 1'b0 || busy_m !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: got done=%b/%b busy=%b/%b want 0", name, done_s, done_m,
               busy_s, busy_m);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    i_start = 1'b1;
    i_bin   = 16'd1234;
    tick();
    tick();
    reset   = 1'b0;
    i_start = 1'b0;
    checks++;
    if (busy_s !== 1'b0 || done_s !== 1'b0 || bcd_s !== 16'h0000 || ovf_s !== 1'b0 ||
        busy_m !== 1'b0 || bcd_m !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b bcd=%h ovf=%b want 0/0/0000/0",
               busy_s, done_s, bcd_s, ovf_s);
    end
    tick();
    checks++;
    if (busy_s !== 1'b0 || bcd_s !== 16'h0000) begin
      failures++;
      $display("FAIL reset_idle_hold: got busy=%b bcd=%h want 0/0000", busy_s, bcd_s);
    end
  endtask

  task automatic test_basic();
    convert(16'd0, "zero");
    convert(16'd1234, "v1234");
    convert(16'd9999, "v9999");
    // Result must hold while idle regardless of i_bin.
    for (int k = 0; k < 5; k++) begin
      i_bin = 16'($urandom);
      tick();
    end
    checks++;
    if (bcd_s !== 16'h9999 || ovf_s !== 1'b0 || done_s !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: got bcd=%h ovf=%b done=%b want 9999/0/0", bcd_s, ovf_s, done_s);
    end
  endtask

  task automatic test_overflow();
    convert(16'd10000, "v10000");
    convert(16'd65535, "v65535");
  endtask

  task automatic test_back_to_back();
    int done_edges[$];
    i_start = 1'b1;
    i_bin   = 16'd42;
    tick();
    i_bin = 16'd777;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done_s === 1'b1) done_edges.push_back(k);
      if (k == 17) begin
        checks++;
        if (bcd_s !== 16'h0042 || bcd_m !== 16'h0042) begin
          failures++;
          $display("FAIL b2b_first: got %h/%h want 0042", bcd_s, bcd_m);
        end
      end
      if (k == 18) begin
        i_start = 1'b0;
        checks++;
        if (busy_s !== 1'b1) begin
          failures++;
          $display("FAIL b2b_accept_e18: got busy=%b want 1", busy_s);
        end
      end
      if (k == 35) begin
        checks++;
        if (bcd_s !== 16'h0777 || bcd_m !== 16'h0777) begin
          failures++;
          $display("FAIL b2b_second: got %h/%h want 0777", bcd_s, bcd_m);
        end
      end
    end
    checks++;
    if (done_edges.size() != 2 || done_edges[0] != 17 || done_edges[1] != 35) begin
      failures++;
      $display("FAIL b2b_done_edges: got %0d pulses (first %0d) want 2 at 17,35",
               done_edges.size(), (done_edges.size() > 0) ? done_edges[0] : -1);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    i_start = 1'b1;
    i_bin   = 16'd500;
    tick();
    i_start = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy_s !== 1'b0 || done_s !== 1'b0 || bcd_s !== 16'h0000 || ovf_s !== 1'b0 ||
        bcd_m !== 16'h0000) begin
      failures++;
      $display("FAIL abort_state: got busy=%b done=%b bcd=%h ovf=%b want 0/0/0000/0",
               busy_s, done_s, bcd_s, ovf_s);
    end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done_s === 1'b1 || done_m === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || bcd_s !== 16'h0000) begin
      failures++;
      $display("FAIL abort_no_done: got %0d pulses bcd=%h want 0/0000", seen, bcd_s);
    end
    convert(16'd5, "after_abort");
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int n = 0; n < 1000; n++) begin
      if (n % 4 == 0) v = 16'($urandom_range(10010, 9990));
      else v = 16'($urandom);
      convert(v, "random");
    end
  endtask

  initial begin
    reset   = 1'b0;
    i_start = 1'b0;
    i_bin   = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
